// File: rtl/switch_seq_detector_pkg.sv
// switch_seq_pkg: shared types and width helpers for switch_seq_detector.
//   state_t  : FSM state (IDLE / TRACK / MATCH), 2-bit encoding seen on the state output
//   calc_cw  : width of a switch-channel code
//   calc_iw  : width of a sequence-table index
//   calc_pw  : width of the progress count (must hold SEQ_LEN itself)
package switch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    MATCH = 2'd2
  } state_t;

  function automatic int calc_cw(input int n_sw);
    return (n_sw > 1) ? $clog2(n_sw) : 1;
  endfunction

  function automatic int calc_iw(input int seq_len);
    return (seq_len > 1) ? $clog2(seq_len) : 1;
  endfunction

  function automatic int calc_pw(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/switch_seq_detector_if.sv
// switch_seq_detector_if: board-side bus of the switch sequence detector.
//   sw        : raw switch levels (asynchronous to clk)
//   prog_*    : sequence-table write port
//   state, progress, match, err_multi, timed_out : status towards display logic
// master = switch/programming side, slave = the detector.
interface switch_seq_detector_if #(
  parameter int N_SW    = 4,
  parameter int SEQ_LEN = 4
) ();
  localparam int CW = switch_seq_pkg::calc_cw(N_SW);
  localparam int IW = switch_seq_pkg::calc_iw(SEQ_LEN);
  localparam int PW = switch_seq_pkg::calc_pw(SEQ_LEN);

  logic [N_SW-1:0] sw;
  logic            prog_en;
  logic [IW-1:0]   prog_idx;
  logic [CW-1:0]   prog_code;
  logic [1:0]      state;
  logic [PW-1:0]   progress;
  logic            match;
  logic            err_multi;
  logic            timed_out;

  modport master (
    output sw, prog_en, prog_idx, prog_code,
    input  state, progress, match, err_multi, timed_out
  );

  modport slave (
    input  sw, prog_en, prog_idx, prog_code,
    output state, progress, match, err_multi, timed_out
  );
endinterface

// File: rtl/switch_seq_detector_debounce.sv
// sw_debounce: single-channel switch debouncer.
//   clk, reset : clock and synchronous active-high reset
//   pb         : raw switch level (asynchronous)
//   level      : filtered level; rises after DB_BITS consecutive highs,
//                falls after DB_BITS consecutive lows, otherwise holds
module sw_debounce #(
  parameter int DB_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pb,
  output logic level
);
  logic [DB_BITS-1:0] sh_q;
  logic               level_q;

  // The shift register doubles as the synchroniser: a metastable first
  // stage can only delay agreement, never fake an all-ones/all-zeros run.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q    <= '0;
      level_q <= 1'b0;
    end else begin
      sh_q <= {sh_q[DB_BITS-2:0], pb};
      if (&sh_q)
        level_q <= 1'b1;
      else if (~|sh_q)
        level_q <= 1'b0;
    end
  end

  assign level = level_q;
endmodule

// File: rtl/switch_seq_detector.sv
// switch_seq_detector: debounces N_SW switches, turns clean rising edges into
// press codes and matches them against a programmable SEQ_LEN-code sequence.
//   clk, reset : clock and synchronous active-high reset
//   bus        : switch inputs, table write port and status outputs
//                (state, progress, match / err_multi / timed_out pulses)
module switch_seq_detector #(
  parameter int N_SW    = 4,
  parameter int SEQ_LEN = 4,
  parameter int DB_BITS = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  switch_seq_detector_if.slave  bus
);
  import switch_seq_pkg::*;

  localparam int CW = calc_cw(N_SW);
  localparam int IW = calc_iw(SEQ_LEN);
  localparam int PW = calc_pw(SEQ_LEN);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [N_SW-1:0] filt;
  logic [N_SW-1:0] filt_q;
  logic [N_SW-1:0] rise;
  logic [CW-1:0]   seq_q [SEQ_LEN];
  state_t          state_q;
  logic [PW-1:0]   progress_q;
  logic [TW-1:0]   cnt_q;
  logic            match_q;
  logic            err_q;
  logic            to_q;

  logic            press_valid;
  logic            press_bad;
  logic [CW-1:0]   press_code;
  logic [CW-1:0]   exp_code;
  logic            code_ok;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_db
    sw_debounce #(.DB_BITS(DB_BITS)) u_db (
      .clk   (clk),
      .reset (reset),
      .pb    (bus.sw[gi]),
      .level (filt[gi])
    );
  end

  assign rise = filt & ~filt_q;

  // A press is valid only when a single channel rose and nothing else is held.
  always_comb begin
    press_code  = '0;
    press_valid = (rise != '0) && ((rise & (rise - N_SW'(1))) == '0) && (filt == rise);
    press_bad   = (rise != '0) && !press_valid;
    for (int i = 0; i < N_SW; i++)
      if (rise[i]) press_code = CW'(i);
  end

  // Expected next code; a mux avoids indexing the table with a wider progress value.
  always_comb begin
    exp_code = seq_q[0];
    for (int i = 0; i < SEQ_LEN; i++)
      if (progress_q == PW'(i)) exp_code = seq_q[i];
  end

  assign code_ok = int'(bus.prog_code) < N_SW;

  // Sequence table; slot indices that do not exist simply never match.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SEQ_LEN; i++)
        seq_q[i] <= CW'(i % N_SW);
    end else if (bus.prog_en && code_ok) begin
      for (int i = 0; i < SEQ_LEN; i++)
        if (bus.prog_idx == IW'(i)) seq_q[i] <= bus.prog_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      progress_q <= '0;
      cnt_q      <= '0;
      filt_q     <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      filt_q  <= filt;
      match_q <= 1'b0;
      to_q    <= 1'b0;
      // Back-to-back rejects collapse so the pulse never stretches.
      err_q   <= press_bad && !err_q;
      if (bus.prog_en) begin
        state_q    <= IDLE;
        progress_q <= '0;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (press_valid && press_code == seq_q[0]) begin
              progress_q <= PW'(1);
              state_q    <= TRACK;
            end
          end
          TRACK: begin
            if (press_valid) begin
              cnt_q <= '0;
              if (press_code == exp_code) begin
                progress_q <= progress_q + PW'(1);
                if (progress_q == PW'(SEQ_LEN - 1)) begin
                  state_q <= MATCH;
                  match_q <= 1'b1;
                end
              end else if (press_code == seq_q[0]) begin
                progress_q <= PW'(1);
              end else begin
                progress_q <= '0;
                state_q    <= IDLE;
              end
            end else if (press_bad) begin
              // Rejected press freezes everything, including the idle counter.
              cnt_q <= cnt_q;
            end else if (TIMEOUT > 0 && cnt_q == TW'(TIMEOUT - 1)) begin
              state_q    <= IDLE;
              progress_q <= '0;
              cnt_q      <= '0;
              to_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q + TW'(1);
            end
          end
          MATCH: begin
            state_q    <= IDLE;
            progress_q <= '0;
            cnt_q      <= '0;
          end
          default: begin
            state_q    <= IDLE;
            progress_q <= '0;
            cnt_q      <= '0;
          end
        endcase
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.progress  = progress_q;
  assign bus.match     = match_q;
  assign bus.err_multi = err_q;
  assign bus.timed_out = to_q;
endmodule

// File: tb/tb_switch_seq_detector.sv
// tb_switch_seq_detector: directed bench for switch_seq_detector with
// DB_BITS=4, TIMEOUT=50, N_SW=4, SEQ_LEN=4. A press driven right after an
// edge is accepted on the 6th following edge (4 to fill the debouncer,
// 1 for the filtered level, 1 for the FSM).
module tb_switch_seq_detector;
  localparam int N_SW    = 4;
  localparam int SEQ_LEN = 4;
  localparam int DB_BITS = 4;
  localparam int TIMEOUT = 50;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  switch_seq_detector_if #(.N_SW(N_SW), .SEQ_LEN(SEQ_LEN)) bus ();

  switch_seq_detector #(
    .N_SW(N_SW), .SEQ_LEN(SEQ_LEN), .DB_BITS(DB_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_begin(input logic [3:0] mask);
    bus.sw = mask;
    repeat (6) tick();
  endtask

  task automatic press_end();
    repeat (4) tick();
    bus.sw = '0;
    repeat (10) tick();
  endtask

  task automatic press(input int ch);
    press_begin(4'(1 << ch));
    press_end();
  endtask

  task automatic expect_st(input string tag, input int st, input int prog);
    check_val({tag, ".state"}, int'(bus.state), st);
    check_val({tag, ".progress"}, int'(bus.progress), prog);
  endtask

  task automatic prog_write(input int idx, input int code);
    bus.prog_en   = 1'b1;
    bus.prog_idx  = 2'(idx);
    bus.prog_code = 2'(code);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset         = 1'b1;
    bus.sw        = '0;
    bus.prog_en   = 1'b0;
    bus.prog_idx  = '0;
    bus.prog_code = '0;
    repeat (3) tick();
    expect_st("reset", 0, 0);
    check_val("reset.match", int'(bus.match), 0);
    check_val("reset.err_multi", int'(bus.err_multi), 0);
    check_val("reset.timed_out", int'(bus.timed_out), 0);
    reset = 1'b0;
    tick();

    // 1: default sequence 0,1,2,3
    press(0); expect_st("t1.p0", 1, 1);
    press(1); expect_st("t1.p1", 1, 2);
    press(2); expect_st("t1.p2", 1, 3);
    press_begin(4'b1000);
    check_val("t1.match", int'(bus.match), 1);
    expect_st("t1.matched", 2, 4);
    tick();
    check_val("t1.match_end", int'(bus.match), 0);
    expect_st("t1.back_idle", 0, 0);
    press_end();

    // 2: glitch is filtered, 4-cycle hold is a press
    press(0); expect_st("t2.p0", 1, 1);
    bus.sw = 4'b0010; repeat (2) tick(); bus.sw = '0; repeat (12) tick();
    expect_st("t2.glitch", 1, 1);
    bus.sw = 4'b0010; repeat (4) tick(); bus.sw = '0; repeat (10) tick();
    expect_st("t2.hold4", 1, 2);

    // 3: two switches together are rejected
    press_begin(4'b0101);
    check_val("t3.err_multi", int'(bus.err_multi), 1);
    expect_st("t3.hold", 1, 2);
    tick();
    check_val("t3.err_end", int'(bus.err_multi), 0);
    bus.sw = '0; repeat (10) tick();
    expect_st("t3.after", 1, 2);

    // 4: wrong code aborts, seq[0] restarts
    press(3); expect_st("t4.abort", 0, 0);
    press(0); expect_st("t4.p0", 1, 1);
    press(1); expect_st("t4.p1", 1, 2);
    press(0); expect_st("t4.restart", 1, 1);
    press(3); expect_st("t4.abort2", 0, 0);

    // 5: timeout after 50 idle cycles in TRACK
    press_begin(4'b0001);
    bus.sw = '0;
    seen = 1'b0;
    repeat (49) begin tick(); seen |= bus.timed_out; end
    check_val("t5.no_early_to", int'(seen), 0);
    check_val("t5.still_track", int'(bus.state), 1);
    tick();
    check_val("t5.timed_out", int'(bus.timed_out), 1);
    expect_st("t5.to_idle", 0, 0);
    tick();
    check_val("t5.to_end", int'(bus.timed_out), 0);
    // press landing in the last idle cycle wins over the timeout
    press_begin(4'b0001);
    bus.sw = '0;
    seen = 1'b0;
    repeat (44) begin tick(); seen |= bus.timed_out; end
    bus.sw = 4'b0010;
    repeat (6) begin tick(); seen |= bus.timed_out; end
    check_val("t5.press_wins", int'(seen), 0);
    expect_st("t5.late_press", 1, 2);
    bus.sw = '0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin tick(); seen = bus.timed_out; end
    check_val("t5.second_to", int'(seen), 1);
    expect_st("t5.idle2", 0, 0);

    // 6: program {3,3,1,0}; a write of code 5 wraps to 1 in the 2-bit
    // field and is overwritten, prog_en aborts an active sequence
    press(0); expect_st("t6.pre", 1, 1);
    prog_write(2, 5);
    prog_write(0, 3);
    prog_write(1, 3);
    prog_write(2, 1);
    prog_write(3, 0);
    bus.prog_en = 1'b0;
    tick();
    expect_st("t6.prog_abort", 0, 0);
    press(0); expect_st("t6.old_first", 0, 0);
    press(3); expect_st("t6.p3a", 1, 1);
    press(3); expect_st("t6.p3b", 1, 2);
    press(1); expect_st("t6.p1", 1, 3);
    press_begin(4'b0001);
    check_val("t6.match", int'(bus.match), 1);
    tick();
    check_val("t6.match_end", int'(bus.match), 0);
    press_end();
    // reset mid-sequence restores the default table
    press(3); press(3); expect_st("t6.mid", 1, 2);
    reset = 1'b1; tick();
    expect_st("t6.reset", 0, 0);
    reset = 1'b0; tick();
    press(3); expect_st("t6.p3_default", 0, 0);
    press(0); press(1); press(2); expect_st("t6.def3", 1, 3);
    press_begin(4'b1000);
    check_val("t6.def_match", int'(bus.match), 1);
    press_end();
    expect_st("t6.final", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
